// File: rtl/mport_ram_pkg.sv
`timescale 1ns/1ps
// Shared memory types and default geometry for the multi-port RAM and memIntf users.
// Types and constants only; no latency and no flow control.
package mport_ram_pkg;
  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 8;
  localparam int NRD_DEF = 8;

  typedef logic [DW_DEF-1:0] Mdata;
  typedef logic [AW_DEF-1:0] Maddr;
endpackage

// File: rtl/mport_rd_lane.sv
`timescale 1ns/1ps
// One read port: write-first bypass, valid-bit lookup and registered output.
// Returns data 1 cycle after rd_en. There is no backpressure, so a request is always accepted.
module mport_rd_lane
  import mport_ram_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic [(1<<AW)-1:0]   valid,
  input  logic [DW-1:0]        mem_data,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_vld,
  output logic                 rd_init,
  output logic                 uninit
);
  logic          hit;
  logic          init;
  logic [DW-1:0] data;

  // An unwritten entry reads as zero, so stale storage never leaks after reset or clr.
  always_comb begin
    hit  = wr_en && (wr_addr == rd_addr);
    init = hit || valid[rd_addr];
    data = hit ? wr_data : (init ? mem_data : '0);
  end

  assign uninit = rd_en && !init;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
      rd_init <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_data <= data;
        rd_init <= init;
      end
    end
  end
endmodule

// File: rtl/mport_ram.sv
`timescale 1ns/1ps
// Single-write, NRD-read RAM with per-entry valid bits and a sticky uninitialised-read flag.
// Reads return 1 cycle after rd_en. There is no backpressure: every port accepts a request each cycle.
module mport_ram
  import mport_ram_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic [NRD-1:0]           rd_en,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][DW-1:0]   rd_data,
  output logic [NRD-1:0]           rd_vld,
  output logic [NRD-1:0]           rd_init,
  output logic                     err_uninit
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [NRD-1:0]   uninit;

  // Storage is never reset; the valid bits alone decide what is reachable.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_addr] <= wr_data;
  end

  // A write in the clr cycle survives, because the later assignment wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (clr)   valid <= '0;
      if (wr_en) valid[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) err_uninit <= 1'b0;
    else if (|uninit)  err_uninit <= 1'b1;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_lane
    mport_rd_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[p]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .valid    (valid),
      .mem_data (mem[rd_addr[p]]),
      .rd_data  (rd_data[p]),
      .rd_vld   (rd_vld[p]),
      .rd_init  (rd_init[p]),
      .uninit   (uninit[p])
    );
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if ($time > 20) begin
      if ($isunknown(wr_en) || (wr_en === 1'b1 && $isunknown(wr_addr)))
        $error("mport_ram: X on write control");
      for (int p = 0; p < NRD; p++)
        if (rd_en[p] === 1'b1 && $isunknown(rd_addr[p]))
          $error("mport_ram: X on rd_addr[%0d]", p);
    end
  end
`endif
endmodule

// File: tb/tb_mport_ram.sv
`timescale 1ns/1ps
// Self-checking bench for mport_ram: directed vector table, corner sequences, random traffic vs reference model.
module tb_mport_ram;
  localparam int DW = 32, AW = 8, NRD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, clr, wr_en;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data;
  logic [NRD-1:0]         rd_en;
  logic [NRD-1:0][AW-1:0] rd_addr;
  logic [NRD-1:0][DW-1:0] rd_data;
  logic [NRD-1:0]         rd_vld, rd_init;
  logic                   err_uninit;

  mport_ram #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_vld(rd_vld), .rd_init(rd_init), .err_uninit(err_uninit)
  );

  int checks = 0, errors = 0;

  // Reference: an associative array holds exactly the entries written since the last reset/clr.
  logic [DW-1:0]          ref_mem [int];
  logic [NRD-1:0]         m_vld, m_init;
  logic [NRD-1:0][DW-1:0] m_data;
  logic                   m_err;

  task automatic model_step();
    logic miss;
    miss = 1'b0;
    if (!rst_n) begin
      ref_mem.delete();
      m_vld = '0; m_init = '0; m_data = '0; m_err = 1'b0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        m_vld[p] = rd_en[p];
        if (rd_en[p]) begin
          if (wr_en && wr_addr == rd_addr[p]) begin
            m_data[p] = wr_data; m_init[p] = 1'b1;
          end else if (ref_mem.exists(int'(rd_addr[p]))) begin
            m_data[p] = ref_mem[int'(rd_addr[p])]; m_init[p] = 1'b1;
          end else begin
            m_data[p] = '0; m_init[p] = 1'b0; miss = 1'b1;
          end
        end
      end
      if (clr) begin
        ref_mem.delete();
        m_err = 1'b0;
      end else if (miss) begin
        m_err = 1'b1;
      end
      if (wr_en) ref_mem[int'(wr_addr)] = wr_data;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0;
    for (int p = 0; p < NRD; p++) rd_addr[p] = '0;
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        cl;
    logic [7:0]  re;
    logic [7:0]  ra;
    int          port;   // -1 checks every port
    logic        vld;
    logic [31:0] data;
    logic        init;
    logic        err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 8'h00,  3, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 32'h0,        1'b0, 8'h08, 8'h10,  3, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 8'h00,  3, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h20, 32'h12345678, 1'b0, 8'hFF, 8'h20, -1, 1'b1, 32'h12345678, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 32'h0,        1'b0, 8'h01, 8'h55,  0, 1'b1, 32'h0,        1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 8'h00,  0, 1'b0, 32'h0,        1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h30, 32'h11,       1'b0, 8'h00, 8'h00,  0, 1'b0, 32'h0,        1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 32'h0,        1'b1, 8'h00, 8'h00,  0, 1'b0, 32'h0,        1'b0, 1'b0};

    rst_n = 1'b0;
    idle();
    tick(); tick();
    chk("reset rd_vld", rd_vld, '0);
    chk("reset rd_data", rd_data, '0);
    chk("reset rd_init", rd_init, '0);
    chk("reset err_uninit", err_uninit, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      clr = tbl[i].cl; rd_en = tbl[i].re;
      for (int p = 0; p < NRD; p++) rd_addr[p] = tbl[i].ra;
      tick();
      for (int p = 0; p < NRD; p++) begin
        if (tbl[i].port < 0 || tbl[i].port == p) begin
          chk($sformatf("vec%0d p%0d rd_vld", i, p), rd_vld[p], tbl[i].vld);
          chk($sformatf("vec%0d p%0d rd_data", i, p), rd_data[p], tbl[i].data);
          if (tbl[i].vld) chk($sformatf("vec%0d p%0d rd_init", i, p), rd_init[p], tbl[i].init);
        end
      end
      chk($sformatf("vec%0d err_uninit", i), err_uninit, tbl[i].err);
      idle();
    end

    // Fill, then clr together with a write: only that entry survives.
    rd_en = 8'h01; rd_addr[0] = 8'h99;
    tick();
    chk("pre-fill err_uninit set", err_uninit, 1'b1);
    idle();
    for (int a = 0; a < 256; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'hA500_0000 | DW'(a);
      tick();
    end
    idle();
    clr = 1'b1; wr_en = 1'b1; wr_addr = 8'h07; wr_data = 32'h0000_00A5;
    rd_en = 8'h02; rd_addr[1] = 8'h10;
    tick();
    chk("clr-edge read rd_vld", rd_vld[1], 1'b1);
    chk("clr-edge read pre-clr data", rd_data[1], 32'hA500_0010);
    chk("clr-edge read pre-clr init", rd_init[1], 1'b1);
    chk("err_uninit after clr", err_uninit, 1'b0);
    idle();
    for (int blk = 0; blk < 32; blk++) begin
      rd_en = '1;
      for (int p = 0; p < NRD; p++) rd_addr[p] = AW'(blk * 8 + p);
      tick();
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("post-clr a%0d rd_init", blk * 8 + p), rd_init[p], (blk * 8 + p) == 7);
        chk($sformatf("post-clr a%0d rd_data", blk * 8 + p), rd_data[p],
            ((blk * 8 + p) == 7) ? 32'h0000_00A5 : 32'h0);
      end
    end
    idle();
    chk("err_uninit sticky after misses", err_uninit, 1'b1);

    // Reset arriving with a read in flight.
    wr_en = 1'b1; wr_addr = 8'h40; wr_data = 32'hCAFEF00D;
    tick();
    idle();
    rst_n = 1'b0; rd_en = 8'h20; rd_addr[5] = 8'h40;
    wr_en = 1'b1; wr_addr = 8'h41; wr_data = 32'h1234;
    tick();
    chk("reset-edge rd_vld[5]", rd_vld[5], 1'b0);
    chk("reset-edge rd_data[5]", rd_data[5], 32'h0);
    chk("reset-edge err_uninit", err_uninit, 1'b0);
    rst_n = 1'b1;
    idle();
    tick();
    chk("post-reset no rd_vld pulse", rd_vld, '0);
    rd_en = 8'h60; rd_addr[5] = 8'h40; rd_addr[6] = 8'h41;
    tick();
    chk("post-reset old addr rd_vld", rd_vld[5], 1'b1);
    chk("post-reset old addr rd_init", rd_init[5], 1'b0);
    chk("post-reset old addr rd_data", rd_data[5], 32'h0);
    chk("write during reset ignored", rd_init[6], 1'b0);
    chk("post-reset miss err_uninit", err_uninit, 1'b1);
    idle();

    // Random traffic on a narrow address window to force bypass and repeated hits.
    for (int c = 0; c < 10000; c++) begin
      rst_n   = ($urandom_range(0, 999) != 0);
      clr     = ($urandom_range(0, 199) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_en   = NRD'($urandom);
      for (int p = 0; p < NRD; p++) rd_addr[p] = AW'($urandom_range(0, 31));
      tick();
      chk($sformatf("rand c%0d rd_vld", c), rd_vld, m_vld);
      chk($sformatf("rand c%0d rd_data", c), rd_data, m_data);
      chk($sformatf("rand c%0d rd_init", c), rd_init & rd_vld, m_init & m_vld);
      chk($sformatf("rand c%0d err_uninit", c), err_uninit, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
